mdu_e: RTL and testbench



---
 rtl/mdu_e.sv | 134 +++++++++++++
 tb/tb_mdu_e.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_e.sv
// ============================================================================
// Module   : mdu_e
// Brief    : E-stage multi-cycle multiply/divide unit owning HI/LO.
//            Optional abort port enabled by defining MDU_CANCEL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_e #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDUSrcA,
    input  logic [31:0] MDUSrcB,
    input  logic [3:0]  MDUOp_E,
`ifdef MDU_CANCEL_EN
    input  logic        cancel_E,
`endif
    output logic        start_E,
    output logic        busy_E,
    output logic [31:0] MDUResult_E
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MTHI  = 4'd5;
    localparam logic [3:0] c_OP_MTLO  = 4'd6;
    localparam logic [3:0] c_OP_MFHI  = 4'd7;
    localparam logic [3:0] c_OP_MFLO  = 4'd8;

    logic [31:0] r_hi, r_lo, r_hi_tmp, r_lo_tmp;
    logic [3:0]  r_cnt;
    logic        r_busy;

    logic        w_cancel;
    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_abs_a, w_abs_b, w_div_b;
    logic [31:0] w_mag_q, w_mag_r, w_sq, w_sr, w_uq, w_ur;
    logic        w_b_zero;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel_E;
`else
    assign w_cancel = 1'b0;
`endif

    // Full 64-bit products; sign-extend the operands for the signed form.
    assign w_prod_s = {{32{MDUSrcA[31]}}, MDUSrcA} * {{32{MDUSrcB[31]}}, MDUSrcB};
    assign w_prod_u = {32'd0, MDUSrcA} * {32'd0, MDUSrcB};

    // Signed division done on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign w_b_zero = (MDUSrcB == 32'd0);
    assign w_abs_a  = MDUSrcA[31] ? (~MDUSrcA + 32'd1) : MDUSrcA;
    assign w_abs_b  = MDUSrcB[31] ? (~MDUSrcB + 32'd1) : MDUSrcB;
    assign w_div_b  = w_b_zero ? 32'd1 : w_abs_b;
    assign w_mag_q  = w_abs_a / w_div_b;
    assign w_mag_r  = w_abs_a % w_div_b;
    assign w_sq     = (MDUSrcA[31] ^ MDUSrcB[31]) ? (~w_mag_q + 32'd1) : w_mag_q;
    assign w_sr     = MDUSrcA[31] ? (~w_mag_r + 32'd1) : w_mag_r;
    assign w_uq     = MDUSrcA / (w_b_zero ? 32'd1 : MDUSrcB);
    assign w_ur     = MDUSrcA % (w_b_zero ? 32'd1 : MDUSrcB);

    assign start_E = (MDUOp_E >= c_OP_MULT) && (MDUOp_E <= c_OP_DIVU) && !r_busy;
    assign busy_E  = r_busy;

    always_comb begin
        MDUResult_E = 32'd0;
        if (MDUOp_E == c_OP_MFHI)
            MDUResult_E = r_hi;
        else if (MDUOp_E == c_OP_MFLO)
            MDUResult_E = r_lo;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_tmp <= 32'd0;
            r_lo_tmp <= 32'd0;
            r_cnt    <= 4'd0;
            r_busy   <= 1'b0;
        end else if (r_busy) begin
            if (w_cancel) begin
                r_cnt  <= 4'd0;
                r_busy <= 1'b0;
            end else if (r_cnt == 4'd1) begin
                r_hi   <= r_hi_tmp;
                r_lo   <= r_lo_tmp;
                r_cnt  <= 4'd0;
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end else if (!w_cancel) begin
            case (MDUOp_E)
                c_OP_MULT: begin
                    r_hi_tmp <= w_prod_s[63:32];
                    r_lo_tmp <= w_prod_s[31:0];
                    r_cnt    <= 4'(MULT_CYCLES);
                    r_busy   <= 1'b1;
                end
                c_OP_MULTU: begin
                    r_hi_tmp <= w_prod_u[63:32];
                    r_lo_tmp <= w_prod_u[31:0];
                    r_cnt    <= 4'(MULT_CYCLES);
                    r_busy   <= 1'b1;
                end
                // A zero divisor stages the current HI/LO so the final write is a no-op.
                c_OP_DIV: begin
                    r_hi_tmp <= w_b_zero ? r_hi : w_sr;
                    r_lo_tmp <= w_b_zero ? r_lo : w_sq;
                    r_cnt    <= 4'(DIV_CYCLES);
                    r_busy   <= 1'b1;
                end
                c_OP_DIVU: begin
                    r_hi_tmp <= w_b_zero ? r_hi : w_ur;
                    r_lo_tmp <= w_b_zero ? r_lo : w_uq;
                    r_cnt    <= 4'(DIV_CYCLES);
                    r_busy   <= 1'b1;
                end
                c_OP_MTHI: r_hi <= MDUSrcA;
                c_OP_MTLO: r_lo <= MDUSrcA;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_e.sv
// ============================================================================
// Module   : tb_mdu_e
// Brief    : Directed self-checking bench for mdu_e (cancel cases need MDU_CANCEL_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_e;

    localparam logic [3:0] c_NONE = 4'd0, c_MULT = 4'd1, c_MULTU = 4'd2,
                           c_DIV = 4'd3, c_DIVU = 4'd4, c_MTHI = 4'd5,
                           c_MTLO = 4'd6, c_MFHI = 4'd7, c_MFLO = 4'd8;
    localparam logic [31:0] c_SHI = 32'hA5A5_A5A5, c_SLO = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MDUSrcA, MDUSrcB;
    logic [3:0]  MDUOp_E;
`ifdef MDU_CANCEL_EN
    logic        cancel_E = 1'b0;
`endif
    logic        start_E, busy_E;
    logic [31:0] MDUResult_E;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .MDUSrcA     (MDUSrcA),
        .MDUSrcB     (MDUSrcB),
        .MDUOp_E     (MDUOp_E),
`ifdef MDU_CANCEL_EN
        .cancel_E    (cancel_E),
`endif
        .start_E     (start_E),
        .busy_E      (busy_E),
        .MDUResult_E (MDUResult_E)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reads HI and LO through MFHI/MFLO within the current low phase.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        MDUOp_E = c_MFHI; #1; hi = MDUResult_E;
        MDUOp_E = c_MFLO; #1; lo = MDUResult_E;
        MDUOp_E = c_NONE; #1;
    endtask

    task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
        MDUOp_E = c_MTHI; MDUSrcA = hi; @(negedge clk);
        MDUOp_E = c_MTLO; MDUSrcA = lo; @(negedge clk);
        MDUOp_E = c_NONE;
    endtask

    // Issues one mult/div at a negedge, returns the number of busy cycles observed.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic st);
        MDUOp_E = op; MDUSrcA = a; MDUSrcB = b; #1;
        st = start_E;
        @(negedge clk);
        MDUOp_E = c_NONE;
        cycles = 0;
        while (busy_E && cycles < 40) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] hi, lo;
        int          cyc;
        logic        st;

        vecs[0] = '{c_MULT,  32'hFFFF_FFFE, 32'd3,        5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{c_MULTU, 32'hFFFF_FFFE, 32'd3,        5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{c_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{c_DIVU,  32'd7,         32'd0,        10, c_SHI,         c_SLO};
        vecs[4] = '{c_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{c_DIVU,  32'd10,        32'd3,        10, 32'd1,         32'd3};
        vecs[6] = '{c_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD};
        vecs[7] = '{c_MULT,  32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{c_DIV,   32'd7,         32'd0,        10, c_SHI,         c_SLO};

        reset = 1'b1; MDUOp_E = c_NONE; MDUSrcA = '0; MDUSrcB = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("reset_busy", {31'd0, busy_E}, 32'd0);
        check("reset_start_none", {31'd0, start_E}, 32'd0);
        read_hilo(hi, lo);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        for (int i = 0; i < 10; i++) begin
            preload(c_SHI, c_SLO);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, st);
            check($sformatf("v%0d_start", i), {31'd0, st}, 32'd1);
            check($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].cyc);
            read_hilo(hi, lo);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
        end

        // MTHI then MFHI in the next cycle.
        MDUOp_E = c_MTHI; MDUSrcA = 32'h1234_5678; @(negedge clk);
        MDUOp_E = c_MFHI; #1;
        check("mthi_mfhi", MDUResult_E, 32'h1234_5678);
        MDUOp_E = c_NONE;

        // Reads during busy see old LO; ops during busy are ignored.
        preload(c_SHI, c_SLO);
        MDUOp_E = c_MULT; MDUSrcA = 32'd4; MDUSrcB = 32'd5; @(negedge clk);
        MDUOp_E = c_MFLO; #1;
        check("mflo_during_busy", MDUResult_E, c_SLO);
        MDUOp_E = c_MULT; MDUSrcA = 32'd9; #1;
        check("start_while_busy", {31'd0, start_E}, 32'd0);
        @(negedge clk);
        MDUOp_E = c_MTLO; MDUSrcA = 32'hDEAD_BEEF; @(negedge clk);
        MDUOp_E = c_NONE;
        cyc = 0;
        while (busy_E && cyc < 40) begin cyc++; @(negedge clk); end
        check("busy_left_after_ignored", cyc, 3);
        read_hilo(hi, lo);
        check("ignored_ops_hi", hi, 32'd0);
        check("ignored_ops_lo", lo, 32'd20);

        // Reset in the third busy cycle of a DIV.
        preload(c_SHI, c_SLO);
        MDUOp_E = c_DIV; MDUSrcA = 32'd100; MDUSrcB = 32'd7; @(negedge clk);
        MDUOp_E = c_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1; @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy_E}, 32'd0);
        read_hilo(hi, lo);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        repeat (12) @(negedge clk);
        read_hilo(hi, lo);
        check("rst_no_late_hi", hi, 32'd0);
        check("rst_no_late_lo", lo, 32'd0);

        // Back-to-back: DIVU accepted in the first non-busy cycle after MULTU.
        run_op(c_MULTU, 32'd2, 32'd3, cyc, st);
        check("b2b_mult_cycles", cyc, 5);
        MDUOp_E = c_MFLO; #1;
        check("b2b_mult_lo", MDUResult_E, 32'd6);
        run_op(c_DIVU, 32'd10, 32'd3, cyc, st);
        check("b2b_div_start", {31'd0, st}, 32'd1);
        check("b2b_div_cycles", cyc, 10);
        read_hilo(hi, lo);
        check("b2b_hi", hi, 32'd1);
        check("b2b_lo", lo, 32'd3);

`ifdef MDU_CANCEL_EN
        // Cancel in the final busy cycle suppresses the write.
        preload(c_SHI, c_SLO);
        MDUOp_E = c_MULT; MDUSrcA = 32'd4; MDUSrcB = 32'd4; @(negedge clk);
        MDUOp_E = c_NONE;
        repeat (4) @(negedge clk);
        cancel_E = 1'b1; @(negedge clk);
        cancel_E = 1'b0;
        check("cancel_busy", {31'd0, busy_E}, 32'd0);
        read_hilo(hi, lo);
        check("cancel_hi", hi, c_SHI);
        check("cancel_lo", lo, c_SLO);
        MDUOp_E = c_MTLO; MDUSrcA = 32'h0BAD_F00D; cancel_E = 1'b1; @(negedge clk);
        cancel_E = 1'b0; MDUOp_E = c_NONE;
        read_hilo(hi, lo);
        check("cancel_mtlo", lo, c_SLO);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
